// File: rtl/sprite_motion_ctrl_if.sv
// Bundle of the PS/2 byte stream, frame pulse and square position/status
// that run between the scan receiver, the motion controller and the pixel generator.
interface sprite_motion_ctrl_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       frame_start;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [3:0] keys;
    logic       update_done;

    modport master (
        output scan_valid, scan_code, frame_start,
        input  pos_x, pos_y, keys, update_done
    );

    modport slave (
        input  scan_valid, scan_code, frame_start,
        output pos_x, pos_y, keys, update_done
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Decodes extended PS/2 arrow make/break codes into a held-key vector and
// moves the square once per frame with acceleration and border clamping.
module sprite_motion_ctrl #(
    parameter int unsigned H_PIXELS     = 640,
    parameter int unsigned V_PIXELS     = 480,
    parameter int unsigned HALF_SIZE    = 10,
    parameter int unsigned BORDER       = 10,
    parameter int unsigned INIT_X       = 320,
    parameter int unsigned INIT_Y       = 240,
    parameter int unsigned MAX_STEP     = 4,
    parameter int unsigned ACCEL_FRAMES = 8
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    sprite_motion_ctrl_if.slave  bus
);

    localparam logic signed [10:0] X_MIN = 11'(BORDER + HALF_SIZE + 1);
    localparam logic signed [10:0] X_MAX = 11'(H_PIXELS - BORDER - HALF_SIZE - 2);
    localparam logic signed [10:0] Y_MIN = 11'(BORDER + HALF_SIZE + 1);
    localparam logic signed [10:0] Y_MAX = 11'(V_PIXELS - BORDER - HALF_SIZE - 2);
    localparam int unsigned        HOLD_MAX = MAX_STEP * ACCEL_FRAMES;
    localparam int unsigned        HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [7:0] CODE_E0    = 8'hE0;
    localparam logic [7:0] CODE_F0    = 8'hF0;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_RIGHT = 8'h74;

    typedef enum logic [1:0] {S_IDLE, S_F0, S_E0, S_E0F0} scan_state_e;
    typedef enum logic [1:0] {M_IDLE, M_CALC, M_APPLY} motion_state_e;

    scan_state_e   scan_q, scan_d;
    motion_state_e mot_q, mot_d;

    logic [3:0]        keys_q, keys_d;
    logic [3:0]        lkeys_q;
    logic [HOLD_W-1:0] hold_q;
    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic              update_done;

    logic [3:0]        arrow_bit;
    logic [HOLD_W-1:0] accel;
    logic signed [10:0] step, dx, dy, cand_x, cand_y;

    // ---------------- scan FSM ----------------
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            scan_q <= S_IDLE;
            keys_q <= '0;
        end else begin
            scan_q <= scan_d;
            keys_q <= keys_d;
        end
    end

    always_comb begin
        scan_d = scan_q;
        if (bus.scan_valid) begin
            case (scan_q)
                S_IDLE: begin
                    if (bus.scan_code == CODE_E0)      scan_d = S_E0;
                    else if (bus.scan_code == CODE_F0) scan_d = S_F0;
                    else                               scan_d = S_IDLE;
                end
                S_E0:    scan_d = (bus.scan_code == CODE_F0) ? S_E0F0 : S_IDLE;
                default: scan_d = S_IDLE;
            endcase
        end
    end

    // Key bit order {up,left,down,right}
    always_comb begin
        arrow_bit = '0;
        case (bus.scan_code)
            CODE_RIGHT: arrow_bit = 4'b0001;
            CODE_DOWN:  arrow_bit = 4'b0010;
            CODE_LEFT:  arrow_bit = 4'b0100;
            CODE_UP:    arrow_bit = 4'b1000;
            default:    arrow_bit = '0;
        endcase
    end

    always_comb begin
        keys_d = keys_q;
        if (bus.scan_valid) begin
            if (scan_q == S_E0)        keys_d = keys_q | arrow_bit;
            else if (scan_q == S_E0F0) keys_d = keys_q & ~arrow_bit;
        end
    end

    // ---------------- motion FSM ----------------
    always_ff @(posedge vga_clk) begin
        if (reset) mot_q <= M_IDLE;
        else       mot_q <= mot_d;
    end

    always_comb begin
        mot_d = mot_q;
        case (mot_q)
            M_IDLE:  if (bus.frame_start) mot_d = M_CALC;
            M_CALC:  mot_d = M_APPLY;
            default: mot_d = M_IDLE;
        endcase
    end

    always_comb begin
        update_done = 1'b0;
        if (mot_q == M_APPLY) update_done = 1'b1;
    end

    // ---------------- datapath ----------------
    always_comb begin
        accel = hold_q / HOLD_W'(ACCEL_FRAMES);
        if (accel >= HOLD_W'(MAX_STEP - 1)) step = 11'(MAX_STEP);
        else                                step = 11'(accel) + 11'sd1;

        dx = '0;
        if (lkeys_q[0] && !lkeys_q[2])      dx = step;
        else if (lkeys_q[2] && !lkeys_q[0]) dx = -step;
        dy = '0;
        if (lkeys_q[1] && !lkeys_q[3])      dy = step;
        else if (lkeys_q[3] && !lkeys_q[1]) dy = -step;

        cand_x = $signed({1'b0, pos_x_q}) + dx;
        cand_y = $signed({1'b0, pos_y_q}) + dy;

        if (cand_x < X_MIN)      pos_x_d = X_MIN[9:0];
        else if (cand_x > X_MAX) pos_x_d = X_MAX[9:0];
        else                     pos_x_d = cand_x[9:0];

        if (cand_y < Y_MIN)      pos_y_d = Y_MIN[9:0];
        else if (cand_y > Y_MAX) pos_y_d = Y_MAX[9:0];
        else                     pos_y_d = cand_y[9:0];
    end

    // Position commits on the edge into M_APPLY so it appears together with update_done.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pos_x_q <= 10'(INIT_X);
            pos_y_q <= 10'(INIT_Y);
            lkeys_q <= '0;
            hold_q  <= '0;
        end else begin
            if (mot_q == M_IDLE && bus.frame_start) lkeys_q <= keys_q;
            if (mot_q == M_CALC) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
            end
            if (mot_q == M_APPLY) begin
                if (|lkeys_q) begin
                    if (hold_q != HOLD_W'(HOLD_MAX)) hold_q <= hold_q + 1'b1;
                end else begin
                    hold_q <= '0;
                end
            end
        end
    end

    assign bus.pos_x       = pos_x_q;
    assign bus.pos_y       = pos_y_q;
    assign bus.keys        = keys_q;
    assign bus.update_done = update_done;

endmodule
